// File: rtl/mnk_pkg.sv
// Shared types and constants for the m,n,k game engine: FSM encodings,
// walker direction deltas and the LFSR polynomial.
package mnk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    RAND  = 3'd2,
    PLACE = 3'd3,
    CHECK = 3'd4,
    NEXT  = 3'd5,
    OVER  = 3'd6
  } state_e;

  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Direction order: horizontal, vertical, diagonal, anti-diagonal.
  function automatic int dir_dr(input logic [1:0] d);
    return (d == 2'd0) ? 0 : 1;
  endfunction

  function automatic int dir_dc(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 0;
      2'd2:    return 1;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/mnk_game_core_if.sv
// Button-side strobes and board-side status of the game core in one bundle.
interface mnk_game_core_if #(
  parameter int N       = 3,
  parameter int PLAYERS = 2
);
  localparam int PW = $clog2(PLAYERS + 1);
  localparam int CW = $clog2(N);

  // start/move/select are single-cycle strobes with no ready: start is taken
  // only in IDLE/OVER, move/select only on a human TURN, otherwise dropped.
  logic                start;
  logic [PW-1:0]       first_player;
  logic                vs_cpu;
  logic                move;
  logic                select;

  logic [N*N*PW-1:0]   board;
  logic [CW-1:0]       cursor_row;
  logic [CW-1:0]       cursor_col;
  logic [PW-1:0]       current_player;
  logic [PW-1:0]       winner;
  logic                draw;
  logic                timeout;
  logic [2:0]          state;

  modport master (
    output start, first_player, vs_cpu, move, select,
    input  board, cursor_row, cursor_col, current_player, winner, draw, timeout, state
  );

  modport slave (
    input  start, first_player, vs_cpu, move, select,
    output board, cursor_row, cursor_col, current_player, winner, draw, timeout, state
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to seed random auto-placement.
module lfsr16
  import mnk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rnd
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rnd <= LFSR_SEED;
    else      rnd <= {rnd[14:0], ^(rnd & LFSR_TAPS)};
  end

endmodule

// File: rtl/mnk_game_core.sv
// N x N, K-in-a-row game FSM with turn timer, random/CPU placement and a
// sequential line walker that checks the four lines through the last mark.
module mnk_game_core
  import mnk_pkg::*;
#(
  parameter int N           = 3,
  parameter int K           = 3,
  parameter int PLAYERS     = 2,
  parameter int TURN_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  mnk_game_core_if.slave  bus
);

  localparam int PW  = $clog2(PLAYERS + 1);
  localparam int CW  = $clog2(N);
  localparam int NN  = N * N;
  localparam int IW  = $clog2(NN);
  localparam int TW  = $clog2(TURN_CYCLES + 1);
  localparam int PCW = IW + 1;

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_TURN  = 3'(TURN);
  localparam logic [2:0] S_RAND  = 3'(RAND);
  localparam logic [2:0] S_PLACE = 3'(PLACE);
  localparam logic [2:0] S_CHECK = 3'(CHECK);
  localparam logic [2:0] S_NEXT  = 3'(NEXT);
  localparam logic [2:0] S_OVER  = 3'(OVER);

  logic [2:0]     state_q;
  logic [PW-1:0]  cells_q [NN];
  logic [CW-1:0]  row_q, col_q;
  logic [PW-1:0]  player_q, winner_q;
  logic           draw_q, cpu_q;
  logic [TW-1:0]  timer_q;
  logic [PCW-1:0] placed_q;
  logic [IW-1:0]  scan_q;
  logic           rand_first_q;
  logic [1:0]     dir_q;
  logic           back_q, alive_q, win_q;
  logic [3:0]     step_q;
  logic [4:0]     cnt_q;
  logic [15:0]    rnd;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .rnd(rnd));

  logic [IW-1:0] cur_idx, rand_idx, walk_idx;
  logic          cpu_turn, sel_ok, timeout_w;
  logic          in_b, match, side_end, dir_win, last_step;
  logic [4:0]    cnt_nx;
  int            sgn, pr, pc;

  assign cur_idx   = IW'(int'(row_q) * N + int'(col_q));
  assign cpu_turn  = cpu_q && (player_q != PW'(1));
  assign sel_ok    = bus.select && (cells_q[cur_idx] == '0);
  // A select that lands on this cycle wins over an expiring timer.
  assign timeout_w = (state_q == S_TURN) && !cpu_turn && !sel_ok &&
                     (timer_q == TW'(TURN_CYCLES - 1));
  assign rand_idx  = rand_first_q ? IW'({16'd0, rnd} % 32'(NN)) : scan_q;

  always_comb begin
    sgn      = back_q ? -1 : 1;
    pr       = int'(row_q) + sgn * int'(step_q) * dir_dr(dir_q);
    pc       = int'(col_q) + sgn * int'(step_q) * dir_dc(dir_q);
    in_b     = (pr >= 0) && (pr < N) && (pc >= 0) && (pc < N);
    walk_idx = in_b ? IW'(pr * N + pc) : '0;
    match    = alive_q && in_b && (cells_q[walk_idx] == player_q);
    cnt_nx   = cnt_q + 5'(match);
    side_end = (step_q == 4'(K - 1));
    dir_win  = (cnt_nx >= 5'(K));
    last_step = side_end && back_q && (dir_q == 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NN; i++) cells_q[i] <= '0;
      row_q        <= '0;
      col_q        <= '0;
      player_q     <= PW'(1);
      winner_q     <= '0;
      draw_q       <= 1'b0;
      cpu_q        <= 1'b0;
      timer_q      <= '0;
      placed_q     <= '0;
      scan_q       <= '0;
      rand_first_q <= 1'b1;
      dir_q        <= '0;
      back_q       <= 1'b0;
      alive_q      <= 1'b1;
      win_q        <= 1'b0;
      step_q       <= 4'd1;
      cnt_q        <= 5'd1;
    end else begin
      rand_first_q <= (state_q != S_RAND);
      case (state_q)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            for (int i = 0; i < NN; i++) cells_q[i] <= '0;
            winner_q <= '0;
            draw_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            timer_q  <= '0;
            placed_q <= '0;
            cpu_q    <= bus.vs_cpu;
            player_q <= (bus.first_player == '0 || bus.first_player > PW'(PLAYERS)) ?
                        PW'(1) : bus.first_player;
            state_q  <= S_TURN;
          end
        end
        S_TURN: begin
          timer_q <= timer_q + TW'(1);
          if (cpu_turn)       state_q <= S_RAND;
          else if (sel_ok)    state_q <= S_PLACE;
          else if (timeout_w) state_q <= S_RAND;
          else if (bus.move) begin
            if (col_q == CW'(N - 1)) begin
              col_q <= '0;
              row_q <= (row_q == CW'(N - 1)) ? '0 : row_q + CW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_RAND: begin
          if (cells_q[rand_idx] == '0) begin
            row_q   <= CW'(int'(rand_idx) / N);
            col_q   <= CW'(int'(rand_idx) % N);
            state_q <= S_PLACE;
          end else begin
            scan_q <= (rand_idx == IW'(NN - 1)) ? '0 : rand_idx + IW'(1);
          end
        end
        S_PLACE: begin
          cells_q[cur_idx] <= player_q;
          placed_q <= placed_q + PCW'(1);
          dir_q    <= '0;
          back_q   <= 1'b0;
          step_q   <= 4'd1;
          alive_q  <= 1'b1;
          cnt_q    <= 5'd1;
          win_q    <= 1'b0;
          state_q  <= S_CHECK;
        end
        S_CHECK: begin
          // Steps past the edge or a foreign mark still take a cycle, so the
          // walk length is fixed at 8(K-1).
          if (side_end) begin
            step_q  <= 4'd1;
            alive_q <= 1'b1;
            if (!back_q) begin
              back_q <= 1'b1;
              cnt_q  <= cnt_nx;
            end else begin
              back_q <= 1'b0;
              dir_q  <= dir_q + 2'd1;
              cnt_q  <= 5'd1;
              win_q  <= win_q | dir_win;
            end
          end else begin
            step_q  <= step_q + 4'd1;
            alive_q <= match;
            cnt_q   <= cnt_nx;
          end
          if (last_step) begin
            if (win_q || dir_win) begin
              winner_q <= player_q;
              state_q  <= S_OVER;
            end else if (placed_q == PCW'(NN)) begin
              draw_q  <= 1'b1;
              state_q <= S_OVER;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          player_q <= (player_q == PW'(PLAYERS)) ? PW'(1) : player_q + PW'(1);
          timer_q  <= '0;
          state_q  <= S_TURN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.board = '0;
    for (int i = 0; i < NN; i++) bus.board[i*PW +: PW] = cells_q[i];
  end

  assign bus.cursor_row     = row_q;
  assign bus.cursor_col     = col_q;
  assign bus.current_player = player_q;
  assign bus.winner         = winner_q;
  assign bus.draw           = draw_q;
  assign bus.timeout        = timeout_w;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_mnk_game_core.sv
// Directed bench for mnk_game_core: a 3x3/K=3/2-player core and a
// 5x5/K=4/3-player core share clock and reset.
module tb_mnk_game_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mnk_game_core_if #(.N(3), .PLAYERS(2)) a ();
  mnk_game_core_if #(.N(5), .PLAYERS(3)) b ();

  mnk_game_core #(.N(3), .K(3), .PLAYERS(2), .TURN_CYCLES(20)) dut_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  mnk_game_core #(.N(5), .K(4), .PLAYERS(3), .TURN_CYCLES(64)) dut_b (
    .clk(clk), .rst(rst), .bus(b)
  );

  int total = 0;
  int bad   = 0;
  int pos_a = 0;
  int pos_b = 0;
  logic [17:0] exp_a = '0;
  logic [49:0] exp_b = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_a(input logic [1:0] fp, input logic cpu);
    a.first_player = fp;
    a.vs_cpu = cpu;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    pos_a = 0;
    exp_a = '0;
  endtask

  // Walk the cursor to idx then strobe select; ends one cycle after select.
  task automatic place_a(input int idx, input logic [1:0] who);
    int steps;
    steps = (idx - pos_a + 9) % 9;
    for (int i = 0; i < steps; i++) begin a.move = 1'b1; tick(); end
    a.move = 1'b0;
    a.select = 1'b1;
    tick();
    a.select = 1'b0;
    pos_a = idx;
    exp_a[idx*2 +: 2] = who;
    total++;
    if (a.state !== 3'd3) begin
      bad++; $display("FAIL place_a_state idx=%0d got=%0d want=3", idx, a.state);
    end
  endtask

  task automatic place_b(input int idx, input logic [1:0] who);
    int steps;
    steps = (idx - pos_b + 25) % 25;
    for (int i = 0; i < steps; i++) begin b.move = 1'b1; tick(); end
    b.move = 1'b0;
    b.select = 1'b1;
    tick();
    b.select = 1'b0;
    pos_b = idx;
    exp_b[idx*2 +: 2] = who;
    total++;
    if (b.state !== 3'd3) begin
      bad++; $display("FAIL place_b_state idx=%0d got=%0d want=3", idx, b.state);
    end
  endtask

  task automatic settle_a();
    int n = 0;
    while (a.state !== 3'd1 && a.state !== 3'd6 && n < 80) begin tick(); n++; end
    total++;
    if (n >= 80) begin bad++; $display("FAIL settle_a state=%0d want=1or6", a.state); end
  endtask

  task automatic settle_b();
    int n = 0;
    while (b.state !== 3'd1 && b.state !== 3'd6 && n < 80) begin tick(); n++; end
    total++;
    if (n >= 80) begin bad++; $display("FAIL settle_b state=%0d want=1or6", b.state); end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if (a.state !== 3'd0 || a.board !== 18'd0 || a.current_player !== 2'd1 ||
        a.winner !== 2'd0 || a.draw !== 1'b0 || a.timeout !== 1'b0 ||
        a.cursor_row !== 2'd0 || a.cursor_col !== 2'd0) begin
      bad++; $display("FAIL reset_a state=%0d board=%h cp=%0d win=%0d draw=%0d to=%0d cur=%0d,%0d want=0 0 1 0 0 0 0,0",
        a.state, a.board, a.current_player, a.winner, a.draw, a.timeout, a.cursor_row, a.cursor_col);
    end
    total++;
    if (b.state !== 3'd0 || b.board !== 50'd0 || b.current_player !== 2'd1) begin
      bad++; $display("FAIL reset_b state=%0d board=%h cp=%0d want=0 0 1", b.state, b.board, b.current_player);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_human_win();
    int n;
    start_a(2'd1, 1'b0);
    total++;
    if (a.state !== 3'd1 || a.current_player !== 2'd1) begin
      bad++; $display("FAIL win_start state=%0d cp=%0d want=1 1", a.state, a.current_player);
    end
    place_a(0, 2'd1); settle_a();
    total++;
    if (a.current_player !== 2'd2 || a.board !== exp_a) begin
      bad++; $display("FAIL win_turn2 cp=%0d board=%h want=2 %h", a.current_player, a.board, exp_a);
    end
    place_a(3, 2'd2); settle_a();
    place_a(1, 2'd1); settle_a();
    place_a(4, 2'd2); settle_a();
    place_a(2, 2'd1);
    tick();
    total++;
    if (a.state !== 3'd4 || a.board !== exp_a) begin
      bad++; $display("FAIL win_check_entry state=%0d board=%h want=4 %h", a.state, a.board, exp_a);
    end
    n = 0;
    while (a.state === 3'd4 && n < 100) begin tick(); n++; end
    total++;
    if (n !== 16) begin bad++; $display("FAIL win_check_len got=%0d want=16", n); end
    total++;
    if (a.state !== 3'd6 || a.winner !== 2'd1 || a.draw !== 1'b0) begin
      bad++; $display("FAIL win_result state=%0d winner=%0d draw=%0d want=6 1 0", a.state, a.winner, a.draw);
    end
  endtask

  task automatic test_draw();
    int cells [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    start_a(2'd3, 1'b0);
    total++;
    if (a.current_player !== 2'd1 || a.winner !== 2'd0 || a.board !== 18'd0) begin
      bad++; $display("FAIL draw_start cp=%0d winner=%0d board=%h want=1 0 0", a.current_player, a.winner, a.board);
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        total++;
        if (a.draw !== 1'b0 || a.state !== 3'd1) begin
          bad++; $display("FAIL draw_before_last draw=%0d state=%0d want=0 1", a.draw, a.state);
        end
      end
      place_a(cells[i], (i % 2 == 0) ? 2'd1 : 2'd2);
      settle_a();
    end
    total++;
    if (a.state !== 3'd6 || a.draw !== 1'b1 || a.winner !== 2'd0 || a.board !== exp_a) begin
      bad++; $display("FAIL draw_result state=%0d draw=%0d winner=%0d board=%h want=6 1 0 %h",
        a.state, a.draw, a.winner, a.board, exp_a);
    end
  endtask

  task automatic test_occupied_select();
    start_a(2'd1, 1'b0);
    place_a(0, 2'd1); settle_a();
    a.select = 1'b1; tick(); a.select = 1'b0;
    total++;
    if (a.state !== 3'd1 || a.board !== exp_a) begin
      bad++; $display("FAIL occ_select state=%0d board=%h want=1 %h", a.state, a.board, exp_a);
    end
    a.move = 1'b1; tick(); a.move = 1'b0;
    pos_a = 1;
    a.move = 1'b1; a.select = 1'b1; tick(); a.move = 1'b0; a.select = 1'b0;
    exp_a[2 +: 2] = 2'd2;
    total++;
    if (a.state !== 3'd3 || a.cursor_row !== 2'd0 || a.cursor_col !== 2'd1) begin
      bad++; $display("FAIL move_select_place state=%0d cur=%0d,%0d want=3 0,1", a.state, a.cursor_row, a.cursor_col);
    end
    tick();
    total++;
    if (a.board !== exp_a || a.cursor_col !== 2'd1) begin
      bad++; $display("FAIL move_select_board board=%h col=%0d want=%h 1", a.board, a.cursor_col, exp_a);
    end
    settle_a();
    total++;
    if (a.state !== 3'd1 || a.current_player !== 2'd1) begin
      bad++; $display("FAIL move_select_next state=%0d cp=%0d want=1 1", a.state, a.current_player);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    int nz = 0;
    int ones = 0;
    pulse_rst();
    start_a(2'd1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      if (a.timeout !== 1'b0) early++;
      tick();
    end
    tick();
    total++;
    if (early !== 0 || a.timeout !== 1'b1 || a.state !== 3'd1) begin
      bad++; $display("FAIL timeout_pulse early=%0d to=%0d state=%0d want=0 1 1", early, a.timeout, a.state);
    end
    tick();
    total++;
    if (a.state !== 3'd2 || a.timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_rand state=%0d to=%0d want=2 0", a.state, a.timeout);
    end
    tick();
    total++;
    if (a.state !== 3'd3) begin bad++; $display("FAIL timeout_rand_len state=%0d want=3", a.state); end
    settle_a();
    for (int i = 0; i < 9; i++) begin
      if (a.board[i*2 +: 2] !== 2'd0) nz++;
      if (a.board[i*2 +: 2] === 2'd1) ones++;
    end
    total++;
    if (nz !== 1 || ones !== 1 || a.current_player !== 2'd2) begin
      bad++; $display("FAIL timeout_auto_place cells=%0d p1cells=%0d cp=%0d want=1 1 2", nz, ones, a.current_player);
    end
  endtask

  task automatic test_rst_mid_check();
    int n = 0;
    while (a.state !== 3'd4 && n < 80) begin tick(); n++; end
    total++;
    if (n >= 80) begin bad++; $display("FAIL rst_reach_check state=%0d want=4", a.state); end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (a.state !== 3'd0 || a.board !== 18'd0 || a.current_player !== 2'd1 || a.winner !== 2'd0 ||
        a.cursor_row !== 2'd0 || a.cursor_col !== 2'd0 || b.state !== 3'd0) begin
      bad++; $display("FAIL rst_async state=%0d board=%h cp=%0d winner=%0d cur=%0d,%0d b_state=%0d want=0 0 1 0 0,0 0",
        a.state, a.board, a.current_player, a.winner, a.cursor_row, a.cursor_col, b.state);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu();
    int twos = 0;
    int nz = 0;
    start_a(2'd2, 1'b1);
    total++;
    if (a.state !== 3'd1 || a.current_player !== 2'd2) begin
      bad++; $display("FAIL cpu_start state=%0d cp=%0d want=1 2", a.state, a.current_player);
    end
    tick();
    total++;
    if (a.state !== 3'd2) begin bad++; $display("FAIL cpu_no_wait state=%0d want=2", a.state); end
    settle_a();
    for (int i = 0; i < 9; i++) begin
      if (a.board[i*2 +: 2] !== 2'd0) nz++;
      if (a.board[i*2 +: 2] === 2'd2) twos++;
    end
    total++;
    if (a.current_player !== 2'd1 || nz !== 1 || twos !== 1) begin
      bad++; $display("FAIL cpu_placed cp=%0d cells=%0d p2cells=%0d want=1 1 1", a.current_player, nz, twos);
    end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (a.state !== 3'd1) begin bad++; $display("FAIL cpu_human_waits state=%0d want=1", a.state); end
  endtask

  task automatic test_anti_diag();
    int cells [10] = '{3, 20, 24, 7, 21, 19, 11, 22, 14, 15};
    logic [1:0] who [10] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    b.first_player = 2'd3; b.vs_cpu = 1'b0;
    b.start = 1'b1; tick(); b.start = 1'b0;
    pos_b = 0; exp_b = '0;
    total++;
    if (b.state !== 3'd1 || b.current_player !== 2'd3) begin
      bad++; $display("FAIL diag_start state=%0d cp=%0d want=1 3", b.state, b.current_player);
    end
    for (int i = 0; i < 10; i++) begin
      place_b(cells[i], who[i]);
      settle_b();
      if (i == 6 || i == 7) begin
        total++;
        if (b.winner !== 2'd0 || b.state !== 3'd1) begin
          bad++; $display("FAIL diag_three_no_win step=%0d winner=%0d state=%0d want=0 1", i, b.winner, b.state);
        end
      end
    end
    total++;
    if (b.state !== 3'd6 || b.winner !== 2'd3 || b.draw !== 1'b0 || b.board !== exp_b) begin
      bad++; $display("FAIL diag_win state=%0d winner=%0d draw=%0d board=%h want=6 3 0 %h",
        b.state, b.winner, b.draw, b.board, exp_b);
    end
  endtask

  initial begin
    a.start = 1'b0; a.first_player = 2'd1; a.vs_cpu = 1'b0; a.move = 1'b0; a.select = 1'b0;
    b.start = 1'b0; b.first_player = 2'd1; b.vs_cpu = 1'b0; b.move = 1'b0; b.select = 1'b0;
    test_reset();
    test_human_win();
    test_draw();
    test_occupied_select();
    test_timeout();
    test_rst_mid_check();
    test_cpu();
    test_anti_diag();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time exceeded total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mnk_game_core.md
# mnk_game_core

Parametrised m,n,k game engine: N×N board, K-in-a-row win, 2..4 players, per-turn timeout with random auto-placement, and optional CPU opponents. It sits between the debounced button/switch inputs and the board display/VGA path. It replaces the fixed 3×3, two-player controller with one FSM-driven core. Win detection is a deterministic sequential line walker around the last placed cell.

## Interface
Parameters:
- N, 3, board side; legal range 3..8.
- K, 3, marks in a row needed to win; legal range 3..N.
- PLAYERS, 2, number of players; legal range 2..4.
- TURN_CYCLES, 1000, cycles allowed per human turn before auto-placement.
- PW, $clog2(PLAYERS+1), cell/player code width (derived, not overridable).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- first_player  in  PW  first player, 1..PLAYERS; sampled on start; out-of-range values map to 1.
- vs_cpu  in  1  sampled on start; when 1, players 2..PLAYERS are CPU-controlled.
- move  in  1  one-cycle pulse; advances the cursor.
- select  in  1  one-cycle pulse; places a mark at the cursor.
- board  out  N*N*PW  cell (r,c) at bits [(r*N+c)*PW +: PW]; 0 = empty, else player code.
- cursor_row, cursor_col  out  $clog2(N) each  cursor position, 0-based.
- current_player  out  PW  player whose turn it is.
- winner  out  PW  0 = none, else the winning player.
- draw  out  1  board filled with no winner.
- timeout  out  1  one-cycle pulse when a human turn expires.
- state  out  3  encoded FSM state.

## Operation
FSM states: IDLE=0, TURN=1, RAND=2, PLACE=3, CHECK=4, NEXT=5, OVER=6.
- IDLE/OVER + start: clear board, winner and draw; cursor to (0,0); current_player = first_player; go to TURN. start in any other state is ignored.
- TURN (human):
  - move: cursor steps row-major; (N-1,N-1) wraps to (0,0).
  - select on an empty cell: go to PLACE. select on an occupied cell is ignored.
  - move and select in the same cycle: select uses the pre-move cursor; move is dropped.
  - turn timer reaches TURN_CYCLES-1: pulse timeout and go to RAND.
- TURN (CPU player, vs_cpu=1): go to RAND immediately.
- RAND:
  - Start index = LFSR value mod N*N.
  - Scan one cell per cycle, ascending with wrap, until an empty cell is found.
  - Set the cursor to that cell and go to PLACE.
- PLACE: write current_player into the cursor cell; increment placed count; go to CHECK.
- CHECK walker:
  - Directions in order: horizontal, vertical, diagonal, anti-diagonal.
  - Per direction: K-1 forward steps, then K-1 backward steps, one step per cycle.
  - A side stops counting at the board edge or a non-matching cell; the remaining steps on that side still consume cycles.
  - count = 1 + matches. If count >= K: winner = current_player, go to OVER after the walk completes.
  - No win and placed count == N*N: draw = 1, go to OVER.
- NEXT: current_player = (current_player mod PLAYERS)+1; clear turn timer; go to TURN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; free-running; reset seed 16'hACE1.

## Timing
- Reset values:
  - board all 0, winner 0, draw 0, timeout 0.
  - state IDLE, current_player 1, cursor (0,0).
  - turn timer 0, placed count 0, LFSR 16'hACE1.
- rst asserted mid-game forces all of the above asynchronously; no partial placement survives.
- Latencies, with select sampled in TURN at cycle t:
  - t+1: state = PLACE.
  - t+2: board cell visible, state = CHECK.
  - CHECK lasts exactly 8(K-1) cycles (16 for K=3).
  - Then NEXT or OVER for one cycle; the next TURN begins 1 cycle after NEXT.
- The turn timer counts only in TURN. timeout asserts the cycle the timer reaches TURN_CYCLES-1.
- RAND latency: 1 + number of occupied cells skipped.
- winner and draw hold until the next start or reset.

## Structure
- Package mnk_pkg:
  - state_e enum with the encodings above.
  - Direction delta constants (dr, dc) for the 4 directions.
  - LFSR tap constant.
- Sub-module lfsr16 (clk, rst, rnd[15:0]).
- The walker, timer and board register stay in mnk_game_core.

## Test plan
- Human win, N=3, K=3, PLAYERS=2, vs_cpu=0, first_player=1. Place P1 (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) -> winner=1, state=OVER; 16 CHECK cycles after the last PLACE.
- Draw, N=3: fill cells with order 1,2,1,1,2,2,2,1,1 row-major -> draw=1, winner=0 after the ninth CHECK.
- Timeout, TURN_CYCLES=20, no input -> timeout pulse at TURN cycle 19, RAND, one empty cell written, current_player advances.
- Occupied select, then simultaneous move+select -> board unchanged on the occupied select; move+select places at the old cursor and the cursor does not advance.
- Anti-diagonal win, N=5, K=4, PLAYERS=3. P3 marks at (0,3),(1,2),(2,1), last at (3,0) -> winner=3. A 3-in-row at K=4 yields no win.
- rst pulse during CHECK -> board all 0, state IDLE, current_player=1. vs_cpu=1 game -> CPU turns never wait on select.
